hex_display_arbiter: RTL and testbench

- Shares the six-digit seven-segment display (hex0..hex5 code buses feeding the per-digit hex decoders) between three message sources, e.g. countdown, banner/title and filter status.
- Contains its own tick divider.
- Grants the display by fixed priority with a non-preemptive minimum hold time, and supports per-source blinking.
- Sits between the application state machines and the hex decoders, replacing direct drive of the digit codes.

---
 rtl/hex_display_arbiter.sv | 178 +++++++++++++++++
 tb/tb_hex_display_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_arbiter.sv
// Shares the six-digit seven-segment display between three message sources using
// fixed priority, a tick-based non-preemptive hold window and per-source blinking.
module hex_display_arbiter #(
   parameter int TICK_DIV = 50000000,
   parameter int MIN_HOLD = 2
) (
   input  logic        clk_50,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [47:0] msg0,
   input  logic [47:0] msg1,
   input  logic [47:0] msg2,
   input  logic [2:0]  blink,
   output logic [2:0]  grant,
   output logic [7:0]  hex0,
   output logic [7:0]  hex1,
   output logic [7:0]  hex2,
   output logic [7:0]  hex3,
   output logic [7:0]  hex4,
   output logic [7:0]  hex5,
   output logic        tick,
   output logic        locked
);

   localparam int CNT_W = $clog2(TICK_DIV);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      OWN  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_tick_cnt;
   logic              r_tick;
   logic [2:0]        r_grant;
   logic [2:0]        w_grant_nxt;
   logic [7:0]        r_hold;
   logic [7:0]        w_hold_nxt;
   logic              r_phase;
   logic              w_phase_nxt;
   logic [2:0]        w_winner;
   logic              w_higher;
   logic              w_owner_req;
   logic              w_any_req;
   logic              w_load;
   logic [47:0]       w_msg;
   logic [47:0]       w_hex;
   logic              w_blank;

   // Free-running tick divider; tick is asserted the cycle after the last count.
   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         r_tick_cnt <= '0;
         r_tick     <= 1'b0;
      end else if (r_tick_cnt == CNT_W'(TICK_DIV - 1)) begin
         r_tick_cnt <= '0;
         r_tick     <= 1'b1;
      end else begin
         r_tick_cnt <= r_tick_cnt + CNT_W'(1);
         r_tick     <= 1'b0;
      end
   end

   // Highest-index asserted request wins.
   always_comb begin
      w_winner = 3'b000;
      if (req[2]) begin
         w_winner = 3'b100;
      end else if (req[1]) begin
         w_winner = 3'b010;
      end else if (req[0]) begin
         w_winner = 3'b001;
      end else begin
         w_winner = 3'b000;
      end
   end

   // One-hot vectors compare numerically in priority order.
   assign w_any_req   = (req != 3'b000);
   assign w_higher    = (w_winner > r_grant);
   assign w_owner_req = |(req & r_grant);
   assign w_load      = ((r_state == IDLE) && w_any_req) ||
                        ((r_state == OWN) && (w_higher || (!w_owner_req && w_any_req)));

   // Next-state logic for grant, hold counter and blink phase.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_hold_nxt  = r_hold;
      w_phase_nxt = r_phase;
      if (w_load) begin
         w_grant_nxt = w_winner;
         w_hold_nxt  = 8'(MIN_HOLD);
         w_phase_nxt = 1'b0;
         w_state_nxt = (MIN_HOLD == 0) ? OWN : HOLD;
      end else begin
         case (r_state)
            IDLE: begin
               w_grant_nxt = 3'b000;
               w_hold_nxt  = 8'd0;
               w_phase_nxt = 1'b0;
               w_state_nxt = IDLE;
            end
            HOLD: begin
               if (r_hold == 8'd0) begin
                  w_state_nxt = OWN;
               end else if (r_tick) begin
                  w_phase_nxt = ~r_phase;
                  w_hold_nxt  = r_hold - 8'd1;
                  w_state_nxt = (r_hold == 8'd1) ? OWN : HOLD;
               end else begin
                  w_state_nxt = HOLD;
               end
            end
            OWN: begin
               if (!w_owner_req) begin
                  w_grant_nxt = 3'b000;
                  w_hold_nxt  = 8'd0;
                  w_phase_nxt = 1'b0;
                  w_state_nxt = IDLE;
               end else if (r_tick) begin
                  w_phase_nxt = ~r_phase;
               end else begin
                  w_phase_nxt = r_phase;
               end
            end
            default: begin
               w_grant_nxt = 3'b000;
               w_hold_nxt  = 8'd0;
               w_phase_nxt = 1'b0;
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_grant <= 3'b000;
         r_hold  <= 8'd0;
         r_phase <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_hold  <= w_hold_nxt;
         r_phase <= w_phase_nxt;
      end
   end

   // Message select from the registered grant; blink is sampled live.
   always_comb begin
      w_msg = 48'd0;
      case (r_grant)
         3'b001:  w_msg = msg0;
         3'b010:  w_msg = msg1;
         3'b100:  w_msg = msg2;
         default: w_msg = 48'd0;
      endcase
   end

   assign w_blank = (|(blink & r_grant)) & r_phase;
   assign w_hex   = w_blank ? 48'd0 : w_msg;

   assign hex0   = w_hex[7:0];
   assign hex1   = w_hex[15:8];
   assign hex2   = w_hex[23:16];
   assign hex3   = w_hex[31:24];
   assign hex4   = w_hex[39:32];
   assign hex5   = w_hex[47:40];
   assign grant  = r_grant;
   assign tick   = r_tick;
   assign locked = (r_hold != 8'd0);

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with TICK_DIV=4, MIN_HOLD=2.
module tb_hex_display_arbiter;

   logic        clk_50;
   logic        rst;
   logic [2:0]  req;
   logic [47:0] msg0;
   logic [47:0] msg1;
   logic [47:0] msg2;
   logic [2:0]  blink;
   logic [2:0]  grant;
   logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
   logic        tick;
   logic        locked;
   logic [47:0] w_hex;

   int n_checks;
   int n_errors;

   localparam logic [47:0] MSG0_V = 48'h0000_0000_0105;
   localparam logic [47:0] MSG1_V = 48'h1122_3344_5566;
   localparam logic [47:0] MSG2_V = 48'hA1B2_C3D4_E5F6;
   localparam logic [47:0] BLK_V  = 48'h0D0D_0D0D_0D0D;

   hex_display_arbiter #(.TICK_DIV(4), .MIN_HOLD(2)) dut (
      .clk_50 (clk_50),
      .rst    (rst),
      .req    (req),
      .msg0   (msg0),
      .msg1   (msg1),
      .msg2   (msg2),
      .blink  (blink),
      .grant  (grant),
      .hex0   (hex0),
      .hex1   (hex1),
      .hex2   (hex2),
      .hex3   (hex3),
      .hex4   (hex4),
      .hex5   (hex5),
      .tick   (tick),
      .locked (locked)
   );

   assign w_hex = {hex5, hex4, hex3, hex2, hex1, hex0};

   initial clk_50 = 1'b0;
   always #5 clk_50 = ~clk_50;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_50);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst   = 1'b1;
      req   = 3'b000;
      msg0  = MSG0_V;
      msg1  = MSG1_V;
      msg2  = MSG2_V;
      blink = 3'b000;

      // Reset state, then release; edges below are counted from release.
      step(2);
      check("rst_grant", 64'(grant), 64'h0);
      check("rst_tick", 64'(tick), 64'h0);
      check("rst_locked", 64'(locked), 64'h0);
      check("rst_hex", 64'(w_hex), 64'h0);
      rst = 1'b0;

      // Edges 1..12: tick on 4, 8, 12; idle display stays blank.
      for (int i = 1; i <= 12; i++) begin
         step(1);
         check("tick_pulse", 64'(tick), ((i % 4) == 0) ? 64'h1 : 64'h0);
         check("idle_grant", 64'(grant), 64'h0);
         check("idle_hex", 64'(w_hex), 64'h0);
      end

      // Single request (t=12): grant at edge 13, hold ticks land at 17 and 21.
      req = 3'b001;
      step(1);
      check("single_grant", 64'(grant), 64'h1);
      check("single_hex0", 64'(hex0), 64'h05);
      check("single_hex1", 64'(hex1), 64'h01);
      check("single_locked", 64'(locked), 64'h1);
      step(7);
      check("single_locked_e20", 64'(locked), 64'h1);
      step(1);
      check("single_unlock_e21", 64'(locked), 64'h0);
      check("single_own_grant", 64'(grant), 64'h1);
      req = 3'b000;
      step(1);
      check("drop_grant", 64'(grant), 64'h0);
      check("drop_hex", 64'(w_hex), 64'h0);

      // Non-preemption (t=22): owner 001 in HOLD, req[2] arrives at t=23.
      req = 3'b001;
      step(1);
      check("np_grant_e23", 64'(grant), 64'h1);
      req = 3'b101;
      for (int i = 24; i <= 29; i++) begin
         step(1);
         check("np_frozen", 64'(grant), 64'h1);
         if (i == 28) check("np_locked_e28", 64'(locked), 64'h1);
         if (i == 29) check("np_unlock_e29", 64'(locked), 64'h0);
      end
      step(1);
      check("np_switch_grant", 64'(grant), 64'h4);
      check("np_switch_locked", 64'(locked), 64'h1);
      check("np_switch_hex", 64'(w_hex), 64'(MSG2_V));
      req = 3'b000;
      step(8);
      check("np_idle_e38", 64'(grant), 64'h0);

      // Preemption in OWN (t=38).
      req = 3'b010;
      step(1);
      check("pre_grant1", 64'(grant), 64'h2);
      step(6);
      check("pre_own_grant", 64'(grant), 64'h2);
      check("pre_own_locked", 64'(locked), 64'h0);
      req = 3'b110;
      step(1);
      check("pre_grant2", 64'(grant), 64'h4);
      check("pre_locked2", 64'(locked), 64'h1);
      check("pre_hex2", 64'(w_hex), 64'(MSG2_V));
      step(7);
      check("pre_own2_grant", 64'(grant), 64'h4);
      check("pre_own2_locked", 64'(locked), 64'h0);
      req = 3'b010;
      step(1);
      check("pre_back_grant", 64'(grant), 64'h2);
      check("pre_back_locked", 64'(locked), 64'h1);
      check("pre_back_hex", 64'(w_hex), 64'(MSG1_V));
      req = 3'b000;
      step(8);
      check("pre_idle_e62", 64'(grant), 64'h0);

      // Blink (t=62): visible on grant, toggles every 4 cycles.
      msg2  = BLK_V;
      blink = 3'b100;
      req   = 3'b100;
      step(1);
      check("blk_e63", 64'(w_hex), 64'(BLK_V));
      step(1);
      check("blk_e64", 64'(w_hex), 64'(BLK_V));
      step(1);
      check("blk_e65", 64'(w_hex), 64'h0);
      step(3);
      check("blk_e68", 64'(w_hex), 64'h0);
      blink = 3'b000;
      #1;
      check("blk_live_off", 64'(w_hex), 64'(BLK_V));
      blink = 3'b100;
      #1;
      check("blk_live_on", 64'(w_hex), 64'h0);
      step(1);
      check("blk_e69", 64'(w_hex), 64'(BLK_V));
      step(3);
      check("blk_e72", 64'(w_hex), 64'(BLK_V));
      step(1);
      check("blk_e73", 64'(w_hex), 64'h0);
      check("blk_e73_grant", 64'(grant), 64'h4);

      // Async reset mid-HOLD.
      req   = 3'b000;
      blink = 3'b000;
      step(1);
      check("ar_idle", 64'(grant), 64'h0);
      req = 3'b001;
      step(1);
      check("ar_hold_grant", 64'(grant), 64'h1);
      check("ar_hold_locked", 64'(locked), 64'h1);
      #2;
      rst = 1'b1;
      #1;
      check("ar_async_grant", 64'(grant), 64'h0);
      check("ar_async_locked", 64'(locked), 64'h0);
      check("ar_async_hex", 64'(w_hex), 64'h0);
      step(2);
      rst = 1'b0;
      step(1);
      check("ar_fresh_grant", 64'(grant), 64'h1);
      check("ar_fresh_locked", 64'(locked), 64'h1);
      check("ar_fresh_hex0", 64'(hex0), 64'h05);
      step(7);
      check("ar_locked_e8", 64'(locked), 64'h1);
      step(1);
      check("ar_unlock_e9", 64'(locked), 64'h0);
      check("ar_own_grant", 64'(grant), 64'h1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
